// File: rtl/br_stats_pkg.sv
// Shared constants for the branch-prediction statistics unit: register map,
// CTRL bit positions and default counter width.
package br_stats_pkg;

   localparam int unsigned CNT_W_DEF = 32;

   localparam logic [3:0] REG_CTRL     = 4'd0;
   localparam logic [3:0] REG_STATUS   = 4'd1;
   localparam logic [3:0] REG_BR_LO    = 4'd2;
   localparam logic [3:0] REG_BR_HI    = 4'd3;
   localparam logic [3:0] REG_HIT_LO   = 4'd4;
   localparam logic [3:0] REG_HIT_HI   = 4'd5;
   localparam logic [3:0] REG_MISPR_LO = 4'd6;
   localparam logic [3:0] REG_MISPR_HI = 4'd7;
   localparam logic [3:0] REG_CYC_LO   = 4'd8;
   localparam logic [3:0] REG_CYC_HI   = 4'd9;

   localparam int unsigned CTRL_EN  = 0;
   localparam int unsigned CTRL_CLR = 1;
   localparam int unsigned CTRL_FRZ = 2;

endpackage

// File: rtl/br_stats_ctr_sat_ctr.sv
// Saturating up-counter with synchronous clear; clear wins over increment and
// the count holds once it reaches all-ones.
module sat_ctr #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q,
   output logic         sat
);

   assign sat = &q;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         q <= '0;
      end else if (inc && !sat) begin
         q <= q + W'(1);
      end
   end

endmodule

// File: rtl/br_stats_ctr.sv
// Branch-prediction statistics block: four saturating counters behind a
// 16-word register window with lo/hi shadow latches for coherent 32-bit reads.
module br_stats_ctr
   import br_stats_pkg::*;
#(
   parameter int unsigned CNT_W     = CNT_W_DEF,
   parameter logic [15:0] BASE_ADDR = 16'hC010
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        inc_br_cnt,
   input  logic        inc_hit_cnt,
   input  logic        inc_mispr_cnt,
   input  logic [15:0] addr,
   input  logic        re,
   input  logic        we,
   input  logic [15:0] wdata,
   output logic [15:0] rdata,
   output logic        sel
);

   logic [3:0]       off;
   logic [1:0]       idx;
   logic             rd_en;
   logic             wr_ctrl;
   logic             clr;
   logic             lo_rd;
   logic             en_q;
   logic             frz_q;
   logic             active;
   logic [CNT_W-1:0] cnt [4];
   logic [31:0]      cnt_ext [4];
   logic [3:0]       sat_vec;
   logic [15:0]      shadow_q [4];
   logic [15:0]      rd_val;
   logic             unused_wdata;

   assign off     = addr[3:0];
   assign sel     = (addr[15:4] == BASE_ADDR[15:4]);
   assign rd_en   = sel & re;
   assign wr_ctrl = sel & we & (off == REG_CTRL);
   assign clr     = wr_ctrl & wdata[CTRL_CLR];
   assign active  = en_q & ~frz_q;
   // Counter index for offsets 2..9: lo/hi pairs map to 0..3.
   assign idx     = 2'(off[3:1] - 3'd1);
   assign lo_rd   = rd_en & (off inside {REG_BR_LO, REG_HIT_LO, REG_MISPR_LO, REG_CYC_LO});

   assign unused_wdata = ^wdata[15:3];

   sat_ctr #(.W(CNT_W)) u_br_ctr (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .inc (inc_br_cnt & active),
      .q   (cnt[0]),
      .sat (sat_vec[0])
   );

   sat_ctr #(.W(CNT_W)) u_hit_ctr (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .inc (inc_hit_cnt & active),
      .q   (cnt[1]),
      .sat (sat_vec[1])
   );

   sat_ctr #(.W(CNT_W)) u_mispr_ctr (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .inc (inc_mispr_cnt & active),
      .q   (cnt[2]),
      .sat (sat_vec[2])
   );

   sat_ctr #(.W(CNT_W)) u_cyc_ctr (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .inc (active),
      .q   (cnt[3]),
      .sat (sat_vec[3])
   );

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         cnt_ext[i] = 32'(cnt[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         en_q  <= 1'b1;
         frz_q <= 1'b0;
      end else if (wr_ctrl) begin
         en_q  <= wdata[CTRL_EN];
         frz_q <= wdata[CTRL_FRZ];
      end
   end

   // Shadow captures the same pre-increment value the lo read returns.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         for (int i = 0; i < 4; i++) begin
            shadow_q[i] <= '0;
         end
      end else if (lo_rd) begin
         shadow_q[idx] <= cnt_ext[idx][31:16];
      end
   end

   always_comb begin
      rd_val = '0;
      case (off)
         REG_CTRL:     rd_val = {13'd0, frz_q, 1'b0, en_q};
         REG_STATUS:   rd_val = {12'd0, sat_vec};
         REG_BR_LO, REG_HIT_LO, REG_MISPR_LO, REG_CYC_LO: rd_val = cnt_ext[idx][15:0];
         REG_BR_HI, REG_HIT_HI, REG_MISPR_HI, REG_CYC_HI: rd_val = shadow_q[idx];
         default:      rd_val = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata <= '0;
      end else if (rd_en) begin
         rdata <= rd_val;
      end
   end

endmodule

// File: tb/tb_br_stats_ctr.sv
// Directed bench for br_stats_ctr: a 32-bit instance for the register window
// and a 17-bit instance whose BR counter is forced to the saturation point.
module tb_br_stats_ctr;
   import br_stats_pkg::*;

   localparam logic [15:0] BASE = 16'hC010;

   logic        clk;
   logic        rst;
   logic        inc_br_cnt;
   logic        inc_hit_cnt;
   logic        inc_mispr_cnt;
   logic [15:0] addr;
   logic        re;
   logic        we;
   logic [15:0] wdata;
   logic [15:0] rdata;
   logic        sel;
   logic [15:0] rdata17;
   logic        sel17;

   int vecs;
   int errs;

   br_stats_ctr #(.CNT_W(32), .BASE_ADDR(BASE)) u_dut (
      .clk           (clk),
      .rst           (rst),
      .inc_br_cnt    (inc_br_cnt),
      .inc_hit_cnt   (inc_hit_cnt),
      .inc_mispr_cnt (inc_mispr_cnt),
      .addr          (addr),
      .re            (re),
      .we            (we),
      .wdata         (wdata),
      .rdata         (rdata),
      .sel           (sel)
   );

   br_stats_ctr #(.CNT_W(17), .BASE_ADDR(BASE)) u_dut17 (
      .clk           (clk),
      .rst           (rst),
      .inc_br_cnt    (inc_br_cnt),
      .inc_hit_cnt   (inc_hit_cnt),
      .inc_mispr_cnt (inc_mispr_cnt),
      .addr          (addr),
      .re            (re),
      .we            (we),
      .wdata         (wdata),
      .rdata         (rdata17),
      .sel           (sel17)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [3:0] off, output logic [15:0] d);
      addr = BASE | {12'd0, off};
      re   = 1'b1;
      tick();
      re   = 1'b0;
      d    = rdata;
   endtask

   task automatic wr(input logic [3:0] off, input logic [15:0] d);
      addr  = BASE | {12'd0, off};
      wdata = d;
      we    = 1'b1;
      tick();
      we    = 1'b0;
   endtask

   task automatic set_strobes(input logic v);
      inc_br_cnt    = v;
      inc_hit_cnt   = v;
      inc_mispr_cnt = v;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      vecs++;
      if (rdata !== 16'h0000) begin
         $display("FAIL reset_rdata: got %h want 0000", rdata);
         errs++;
      end
   endtask

   task automatic test_idle();
      logic [15:0] d;
      rd(REG_CTRL, d);
      vecs++;
      if (d !== 16'h0001) begin
         $display("FAIL idle_ctrl: got %h want 0001", d);
         errs++;
      end
      rd(REG_BR_LO, d);
      vecs++;
      if (d !== 16'h0000) begin
         $display("FAIL idle_br_lo: got %h want 0000", d);
         errs++;
      end
      // Two reads plus nine idle cycles: the CYC_LO read sees 11 increments.
      repeat (9) tick();
      rd(REG_CYC_LO, d);
      vecs++;
      if (d !== 16'd11) begin
         $display("FAIL idle_cyc_lo: got %0d want 11", d);
         errs++;
      end
   endtask

   task automatic test_all_strobes();
      logic [15:0] d;
      set_strobes(1'b1);
      repeat (3) tick();
      set_strobes(1'b0);
      rd(REG_BR_LO, d);
      vecs++;
      if (d !== 16'd3) begin
         $display("FAIL strobe_br_lo: got %0d want 3", d);
         errs++;
      end
      rd(REG_HIT_LO, d);
      vecs++;
      if (d !== 16'd3) begin
         $display("FAIL strobe_hit_lo: got %0d want 3", d);
         errs++;
      end
      rd(REG_MISPR_LO, d);
      vecs++;
      if (d !== 16'd3) begin
         $display("FAIL strobe_mispr_lo: got %0d want 3", d);
         errs++;
      end
   endtask

   task automatic test_clr_frz();
      logic [15:0] d;
      inc_br_cnt  = 1'b1;
      inc_hit_cnt = 1'b1;
      wr(REG_CTRL, 16'h0003);
      inc_br_cnt  = 1'b0;
      inc_hit_cnt = 1'b0;
      rd(REG_BR_LO, d);
      vecs++;
      if (d !== 16'h0000) begin
         $display("FAIL clr_br_lo: got %h want 0000", d);
         errs++;
      end
      rd(REG_CTRL, d);
      vecs++;
      if (d !== 16'h0001) begin
         $display("FAIL clr_ctrl_readback: got %h want 0001", d);
         errs++;
      end
      // CYC: cleared, then +1 per cycle for the two reads and the FRZ write cycle.
      wr(REG_CTRL, 16'h0005);
      inc_br_cnt = 1'b1;
      repeat (5) tick();
      inc_br_cnt = 1'b0;
      rd(REG_BR_LO, d);
      vecs++;
      if (d !== 16'h0000) begin
         $display("FAIL frz_br_lo: got %h want 0000", d);
         errs++;
      end
      rd(REG_HIT_LO, d);
      vecs++;
      if (d !== 16'h0000) begin
         $display("FAIL frz_hit_lo: got %h want 0000", d);
         errs++;
      end
      rd(REG_CYC_LO, d);
      vecs++;
      if (d !== 16'd3) begin
         $display("FAIL frz_cyc_lo: got %0d want 3", d);
         errs++;
      end
      wr(REG_CTRL, 16'h0001);
   endtask

   task automatic test_misc();
      logic [15:0] d;
      rd(REG_STATUS, d);
      vecs++;
      if (d !== 16'h0000) begin
         $display("FAIL status_idle: got %h want 0000", d);
         errs++;
      end
      wr(4'd10, 16'hFFFF);
      rd(4'd10, d);
      vecs++;
      if (d !== 16'h0000) begin
         $display("FAIL unused_reg: got %h want 0000", d);
         errs++;
      end
      // Read and write CTRL together: read returns the pre-write value.
      addr  = BASE;
      wdata = 16'h0005;
      re    = 1'b1;
      we    = 1'b1;
      tick();
      re    = 1'b0;
      we    = 1'b0;
      vecs++;
      if (rdata !== 16'h0001) begin
         $display("FAIL rw_same_cycle: got %h want 0001", rdata);
         errs++;
      end
      rd(REG_CTRL, d);
      vecs++;
      if (d !== 16'h0005) begin
         $display("FAIL rw_ctrl_after: got %h want 0005", d);
         errs++;
      end
      addr  = 16'hC020;
      wdata = 16'h0000;
      re    = 1'b1;
      we    = 1'b1;
      #1;
      vecs++;
      if (sel !== 1'b0) begin
         $display("FAIL sel_outside: got %b want 0", sel);
         errs++;
      end
      tick();
      re = 1'b0;
      we = 1'b0;
      vecs++;
      if (rdata !== 16'h0005) begin
         $display("FAIL unsel_rdata_hold: got %h want 0005", rdata);
         errs++;
      end
      rd(REG_CTRL, d);
      vecs++;
      if (d !== 16'h0005) begin
         $display("FAIL unsel_write_ignored: got %h want 0005", d);
         errs++;
      end
      wr(REG_CTRL, 16'h0001);
   endtask

   task automatic test_preload();
      logic [15:0] d;
      wr(REG_CTRL, 16'h0003);
      inc_br_cnt = 1'b1;
      repeat (65535) tick();
      inc_br_cnt = 1'b0;
      rd(REG_BR_LO, d);
      vecs++;
      if (d !== 16'hFFFF) begin
         $display("FAIL preload_lo: got %h want FFFF", d);
         errs++;
      end
      inc_br_cnt = 1'b1;
      rd(REG_BR_HI, d);
      inc_br_cnt = 1'b0;
      vecs++;
      if (d !== 16'h0000) begin
         $display("FAIL preload_hi_shadow: got %h want 0000", d);
         errs++;
      end
      rd(REG_BR_LO, d);
      vecs++;
      if (d !== 16'h0000) begin
         $display("FAIL rollover_lo: got %h want 0000", d);
         errs++;
      end
      rd(REG_BR_HI, d);
      vecs++;
      if (d !== 16'h0001) begin
         $display("FAIL rollover_hi: got %h want 0001", d);
         errs++;
      end
   endtask

   task automatic test_sat17();
      logic [15:0] d;
      force u_dut17.u_br_ctr.q = 17'h1FFFF;
      tick();
      release u_dut17.u_br_ctr.q;
      inc_br_cnt = 1'b1;
      tick();
      inc_br_cnt = 1'b0;
      rd(REG_BR_LO, d);
      vecs++;
      if (rdata17 !== 16'hFFFF) begin
         $display("FAIL sat17_lo: got %h want FFFF", rdata17);
         errs++;
      end
      rd(REG_BR_HI, d);
      vecs++;
      if (rdata17 !== 16'h0001) begin
         $display("FAIL sat17_hi: got %h want 0001", rdata17);
         errs++;
      end
      rd(REG_STATUS, d);
      vecs++;
      if (rdata17 !== 16'h0001) begin
         $display("FAIL sat17_status: got %h want 0001", rdata17);
         errs++;
      end
      vecs++;
      if (d !== 16'h0000) begin
         $display("FAIL status32_unsat: got %h want 0000", d);
         errs++;
      end
   endtask

   task automatic test_reset_mid();
      logic [15:0] d;
      wr(REG_CTRL, 16'h0005);
      set_strobes(1'b1);
      rd(REG_CTRL, d);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      vecs++;
      if (rdata !== 16'h0000) begin
         $display("FAIL midrst_rdata: got %h want 0000 (prev %h)", rdata, d);
         errs++;
      end
      rd(REG_BR_LO, d);
      set_strobes(1'b0);
      vecs++;
      if (d !== 16'h0000) begin
         $display("FAIL midrst_br_lo: got %h want 0000", d);
         errs++;
      end
      rd(REG_BR_HI, d);
      vecs++;
      if (d !== 16'h0000) begin
         $display("FAIL midrst_br_hi: got %h want 0000", d);
         errs++;
      end
      rd(REG_CTRL, d);
      vecs++;
      if (d !== 16'h0001) begin
         $display("FAIL midrst_ctrl: got %h want 0001", d);
         errs++;
      end
   endtask

   initial begin
      vecs  = 0;
      errs  = 0;
      rst   = 1'b1;
      addr  = BASE;
      re    = 1'b0;
      we    = 1'b0;
      wdata = 16'h0000;
      set_strobes(1'b0);
      test_reset();
      test_idle();
      test_all_strobes();
      test_clr_frz();
      test_misc();
      test_preload();
      test_sat17();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
